// File: rtl/debouncer_multi.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_multi
// Purpose  : CHANNELS independent contact debouncers with per-channel polarity,
//            giving a debounced level plus one-cycle press/release pulses.
//            Auto-repeat of press while held is built when DEBOUNCER_REPEAT_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
module debouncer_multi #(
    parameter int unsigned            CHANNELS        = 4,
    parameter int unsigned            COUNT_WIDTH     = 16,
    parameter logic [COUNT_WIDTH-1:0] COUNT_END       = 16'd50000,
    parameter logic [CHANNELS-1:0]    ACTIVE_LOW_MASK = '0,
    parameter logic [23:0]            REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0]            REPEAT_PERIOD   = 24'd1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_event
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_PRESSED   = 2'd1;
    localparam logic [1:0] c_ST_HELD      = 2'd2;
    localparam logic [1:0] c_ST_RELEASING = 2'd3;

    logic r_any_event;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic                   r_sync1;
            logic                   r_sync2;
            logic [1:0]             r_state;
            logic [1:0]             w_state_nxt;
            logic [COUNT_WIDTH-1:0] r_cnt;
            logic [COUNT_WIDTH-1:0] w_cnt_nxt;
            logic                   r_level;
            logic                   r_press;
            logic                   r_release;
            logic                   w_level_nxt;
            logic                   w_press_nxt;
            logic                   w_release_nxt;
            logic                   w_s;
            logic                   w_cnt_done;
            logic                   w_rep_fire;

            assign w_s        = r_sync2;
            assign w_cnt_done = (r_cnt == COUNT_END);

            // Polarity is corrected before synchronising, so reset leaves "not pressed".
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= in[gi] ^ ACTIVE_LOW_MASK[gi];
                    r_sync2 <= r_sync1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state   <= c_ST_IDLE;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_level   <= w_level_nxt;
                    r_press   <= w_press_nxt;
                    r_release <= w_release_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = '0;
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_s) w_state_nxt = c_ST_PRESSED;
                    end
                    c_ST_PRESSED: begin
                        if (!w_s)           w_state_nxt = c_ST_IDLE;
                        else if (w_cnt_done) w_state_nxt = c_ST_HELD;
                        else                 w_cnt_nxt   = r_cnt + 1'b1;
                    end
                    c_ST_HELD: begin
                        if (!w_s) w_state_nxt = c_ST_RELEASING;
                    end
                    c_ST_RELEASING: begin
                        if (w_s)             w_state_nxt = c_ST_HELD;
                        else if (w_cnt_done) w_state_nxt = c_ST_IDLE;
                        else                 w_cnt_nxt   = r_cnt + 1'b1;
                    end
                    default: begin
                        w_state_nxt = c_ST_IDLE;
                    end
                endcase
            end

            always_comb begin
                w_level_nxt   = r_level;
                w_press_nxt   = w_rep_fire;
                w_release_nxt = 1'b0;
                case (r_state)
                    c_ST_PRESSED: begin
                        if (w_s && w_cnt_done) begin
                            w_level_nxt = 1'b1;
                            w_press_nxt = 1'b1;
                        end
                    end
                    c_ST_RELEASING: begin
                        if (!w_s && w_cnt_done) begin
                            w_level_nxt   = 1'b0;
                            w_release_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_level_nxt = r_level;
                    end
                endcase
            end

`ifdef DEBOUNCER_REPEAT_EN
            logic [23:0] r_rep_cnt;
            logic        r_rep_first;
            logic        w_in_held;
            logic [23:0] w_rep_target;

            // Counting only while HELD with the input still active means any exit,
            // including a bounce through RELEASING, restarts from the full delay.
            assign w_in_held    = (r_state == c_ST_HELD) && w_s;
            assign w_rep_target = r_rep_first ? REPEAT_DELAY : REPEAT_PERIOD;
            assign w_rep_fire   = w_in_held && (r_rep_cnt == (w_rep_target - 24'd1));

            always_ff @(posedge clk) begin
                if (reset || !w_in_held) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if (w_rep_fire) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b0;
                end else begin
                    r_rep_cnt   <= r_rep_cnt + 24'd1;
                end
            end
`else
            assign w_rep_fire = 1'b0;
`endif

            assign level[gi]         = r_level;
            assign press[gi]         = r_press;
            assign release_pulse[gi] = r_release;
        end
    endgenerate

`ifndef DEBOUNCER_REPEAT_EN
    logic w_unused_repeat;
    assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk) begin
        if (reset) r_any_event <= 1'b0;
        else       r_any_event <= |(press | release_pulse);
    end

    assign any_event = r_any_event;

endmodule
`default_nettype wire

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised successor of the single-input push-button debouncer.
- Debounces CHANNELS independent contact inputs, each with a per-channel polarity.
- Per channel, provides a debounced level plus single-cycle press and release pulses.
- Sits between front-panel/connector inputs and the executor control logic; feeds start/step/abort commands.

Parameters:
CHANNELS, 4, number of independent input channels (1..32)
COUNT_WIDTH, 16, width of each per-channel debounce counter
COUNT_END, 16'd50000, terminal counter value; must fit in COUNT_WIDTH; 0 is legal
ACTIVE_LOW_MASK, 0 (CHANNELS bits), bit i = 1: channel i is pressed when in[i] is low
REPEAT_DELAY, 24'd5000000, cycles in HELD before first auto-repeat (optional feature only)
REPEAT_PERIOD, 24'd1000000, cycles between subsequent auto-repeats (optional feature only)

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
in  input  CHANNELS  raw bouncing contact inputs, asynchronous to clk
level  output  CHANNELS  debounced pressed state, 1 = pressed
press  output  CHANNELS  one-cycle H pulse when a press is accepted
release  output  CHANNELS  one-cycle H pulse when a release is accepted
any_event  output  1  registered OR of press|release across all channels

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset clears:
  - all counters to 0;
  - all FSMs to IDLE;
  - level, press, release and any_event to 0;
  - the synchroniser flops to the inactive value (0 after polarity correction).
- Reset asserted mid-debounce aborts that debounce; no pulse is emitted.
- Input conditioning, per channel:
  - p[i] = in[i] XOR ACTIVE_LOW_MASK[i];
  - p[i] passes through a 2-flop synchroniser to give s[i];
  - s[i] is the only value the FSM sees.
- Per-channel FSM, 2-bit state: IDLE, PRESSED, HELD, RELEASING.
  - IDLE: if s = 1, go to PRESSED; counter holds 0.
  - PRESSED:
    - if s = 0: clear counter, go to IDLE;
    - else, if counter == COUNT_END: level <= 1, press <= 1 for one cycle, clear counter, go to HELD;
    - else: counter increments.
  - HELD: if s = 0, go to RELEASING with counter = 0.
  - RELEASING:
    - if s = 1 (bounce): clear counter, go to HELD; level stays 1, no pulse;
    - else, if counter == COUNT_END: level <= 0, release <= 1 for one cycle, clear counter, go to IDLE;
    - else: counter increments.
  - Illegal state encoding: go to IDLE, clear counter.
- Latency: in[i] first sampled active at edge t0 → press[i] high in the cycle after edge t0+COUNT_END+3, provided the input stays active throughout. Release latency is identical.
- Width rules:
  - the counter never exceeds COUNT_END, so no wrap-around is possible;
  - COUNT_END = 0 gives the minimum latency of 3 edges.
- Pulse rules:
  - press and release are never both high on one channel in the same cycle;
  - the minimum spacing between a press and the following release on a channel is COUNT_END+2 cycles.
- Channels are fully independent. Simultaneous events on several channels each assert their own bit in the same cycle.
- any_event is registered: it is high one cycle after any press or release bit is high.

Optional Feature:
- Macro: DEBOUNCER_REPEAT_EN.
- Defined:
  - each channel gets a 24-bit repeat counter, cleared on entry to HELD and counting while in HELD;
  - at REPEAT_DELAY it emits a press pulse and reloads;
  - thereafter it emits a press pulse every REPEAT_PERIOD cycles;
  - leaving HELD (including RELEASING→HELD bounce recovery) restarts the count from 0;
  - a repeat pulse also drives any_event.
- Not defined: no repeat counters exist; press fires exactly once per accepted press; REPEAT_* parameters are ignored.

Test Plan:
1. Reset, then CHANNELS=4, COUNT_END=3, in[0] steady high from edge 10 → press[0] high for exactly the cycle after edge 16; level[0]=1 from then on; any_event high the following cycle.
2. in[1] toggles high 2 cycles / low 1 cycle ×5, then stays high (COUNT_END=3) → no press during bouncing; single press 7 cycles after the final rise.
3. ACTIVE_LOW_MASK=4'b0100, in[2] driven 0 then 1 (each held ≥10 cycles) → press[2] then release[2], each one cycle wide; level[2] follows the pressed state.
4. Channels 0 and 3 both released within the same cycle after HELD → release[0] and release[3] asserted in the same cycle; level clears on both; a 2-cycle low glitch during HELD gives no release.
5. reset asserted for 1 cycle while channel 0 is in PRESSED with counter=2 → all outputs 0 next cycle; no press afterwards unless the input is re-held for the full debounce time.
6. DEBOUNCER_REPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=8, in[0] held for 60 cycles → press at the debounce point, then at +20, +28, +36, ...; a single release after the input drops.
